// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and valid/ready read port.
// Flags framing errors and dropped bytes with single-cycle registered pulses.
module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          framing_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    // state     | meaning
    // IDLE      | line idle, waiting for a falling edge
    // START     | confirming the start bit at its midpoint
    // DATA      | sampling 8 data bits, LSB first
    // STOP      | sampling the stop bit, push or flag
    // WAIT_IDLE | after a bad stop bit, wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          r_rx_meta;
    logic          r_rxs;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_sh;
    logic          r_framing_err;
    logic          r_overflow;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_sh_nxt;
    logic          w_push_req;
    logic          w_ferr;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_push_req  = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_sh_nxt  = {r_rxs, r_sh[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign valid_o = (r_count != '0);
    assign w_pop   = valid_o && ready_i;
    assign w_full  = (r_count == DEPTH_N);
    assign w_wr    = w_push_req && (!w_full || w_pop);
    assign w_ovf   = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_sh;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_framing_err <= w_ferr;
            r_overflow    <= w_ovf;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o        = valid_o ? r_mem[r_rd_ptr] : 8'h00;
    assign count_o       = r_count;
    assign framing_err_o = r_framing_err;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered (CLKS_PER_BIT=8, FIFO_DEPTH=8).
// Frames are driven on falling clock edges; outputs are checked on falling edges.
module tb_uart_rx_buffered;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       framing_err_o;
    logic       overflow_o;
    logic [3:0] count_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;
    int t_valid = -1;
    int t_ferr = -1;
    int t_ovf = -1;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic prev_valid = 1'b0;

    uart_rx_buffered #(.CLKS_PER_BIT(8), .FIFO_DEPTH(8)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .rx_i(rx_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .framing_err_o(framing_err_o),
        .overflow_o(overflow_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        prev_valid <= valid_o;
        if (valid_o && !prev_valid) t_valid <= cyc;
        if (framing_err_o) begin
            t_ferr   <= cyc;
            ferr_cnt <= ferr_cnt + 1;
        end
        if (overflow_o) begin
            t_ovf   <= cyc;
            ovf_cnt <= ovf_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 80-cycle frame starting at a falling edge. pop_at raises ready_i for
    // exactly one cycle before that offset; abort_at asserts reset and returns early.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                              input int abort_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 80; i++) begin
            if (i == abort_at) begin
                rst_i = 1'b1;
                return;
            end
            rx_i = fr[i/8];
            if (i == pop_at) ready_i = 1'b1;
            else if (pop_at >= 0 && i == pop_at + 1) ready_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic pop_and_check(input string tag, input logic [7:0] exp [], input int n);
        ready_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk(tag, {24'h0, data_o}, {24'h0, exp[k]});
            @(negedge clk_i);
        end
        ready_i = 1'b0;
        chk({tag, "_empty"}, {28'h0, count_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_ok [];
        logic [7:0] exp_ovf [];

        idle_cycles(3);
        chk("rst_count", {28'h0, count_o}, 32'd0);
        chk("rst_valid", {31'h0, valid_o}, 32'd0);
        chk("rst_data", {24'h0, data_o}, 32'h00);
        chk("rst_ferr", {31'h0, framing_err_o}, 32'd0);
        chk("rst_ovf", {31'h0, overflow_o}, 32'd0);
        rst_i = 1'b0;
        idle_cycles(4);

        // Single frame: 2 sync + 4 start + 72 data/stop + 1 register = valid 79 cycles on.
        send_frame(8'hA5, 1'b1, -1, -1);
        chk("single_valid", {31'h0, valid_o}, 32'd1);
        chk("single_data", {24'h0, data_o}, 32'hA5);
        chk("single_count", {28'h0, count_o}, 32'd1);
        chk("single_latency", t_valid - last_start, 32'd79);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("single_pop_count", {28'h0, count_o}, 32'd0);
        chk("single_pop_valid", {31'h0, valid_o}, 32'd0);
        chk("single_pop_data", {24'h0, data_o}, 32'h00);
        idle_cycles(4);

        // Back-to-back "OK\n"
        send_frame(8'h4F, 1'b1, -1, -1);
        send_frame(8'h4B, 1'b1, -1, -1);
        send_frame(8'h0A, 1'b1, -1, -1);
        chk("b2b_count", {28'h0, count_o}, 32'd3);
        chk("b2b_ferr", ferr_cnt, 32'd0);
        chk("b2b_ovf", ovf_cnt, 32'd0);
        exp_ok = '{8'h4F, 8'h4B, 8'h0A};
        pop_and_check("b2b_pop", exp_ok, 3);
        idle_cycles(4);

        // Overflow: ninth frame dropped
        for (int k = 0; k < 9; k++) send_frame(8'(k), 1'b1, -1, -1);
        idle_cycles(2);
        chk("ovf_pulses", ovf_cnt, 32'd1);
        chk("ovf_latency", t_ovf - last_start, 32'd79);
        chk("ovf_count", {28'h0, count_o}, 32'd8);
        chk("ovf_ferr", ferr_cnt, 32'd0);
        exp_ovf = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        pop_and_check("ovf_pop", exp_ovf, 8);
        idle_cycles(4);

        // Full FIFO with a pop coinciding with the ninth stop sample keeps 0x08
        for (int k = 0; k < 8; k++) send_frame(8'(k), 1'b1, -1, -1);
        send_frame(8'h08, 1'b1, 78, -1);
        idle_cycles(2);
        chk("ovfpop_pulses", ovf_cnt, 32'd1);
        chk("ovfpop_count", {28'h0, count_o}, 32'd8);
        exp_ovf = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        pop_and_check("ovfpop_pop", exp_ovf, 8);
        idle_cycles(4);

        // Framing error followed by a break of 3 bit times
        send_frame(8'h55, 1'b0, -1, -1);
        rx_i = 1'b0;
        idle_cycles(24);
        rx_i = 1'b1;
        idle_cycles(16);
        chk("ferr_pulses", ferr_cnt, 32'd1);
        chk("ferr_latency", t_ferr - last_start, 32'd79);
        chk("ferr_count", {28'h0, count_o}, 32'd0);
        chk("ferr_ovf", ovf_cnt, 32'd1);
        send_frame(8'h3C, 1'b1, -1, -1);
        chk("after_ferr_count", {28'h0, count_o}, 32'd1);
        chk("after_ferr_data", {24'h0, data_o}, 32'h3C);
        idle_cycles(4);

        // Two-cycle glitch on an idle line
        rx_i = 1'b0;
        idle_cycles(2);
        rx_i = 1'b1;
        idle_cycles(20);
        chk("glitch_count", {28'h0, count_o}, 32'd1);
        chk("glitch_ferr", ferr_cnt, 32'd1);
        chk("glitch_ovf", ovf_cnt, 32'd1);

        // Reset during data bit 4 of 0xFF while 0x3C is still queued
        send_frame(8'hFF, 1'b1, -1, 44);
        #1;
        chk("midrst_count", {28'h0, count_o}, 32'd0);
        chk("midrst_valid", {31'h0, valid_o}, 32'd0);
        chk("midrst_data", {24'h0, data_o}, 32'h00);
        chk("midrst_ferr", {31'h0, framing_err_o}, 32'd0);
        chk("midrst_ovf", {31'h0, overflow_o}, 32'd0);
        @(negedge clk_i);
        rx_i = 1'b1;
        idle_cycles(2);
        rst_i = 1'b0;
        idle_cycles(4);
        send_frame(8'h12, 1'b1, -1, -1);
        chk("postrst_count", {28'h0, count_o}, 32'd1);
        chk("postrst_data", {24'h0, data_o}, 32'h12);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("postrst_pop_count", {28'h0, count_o}, 32'd0);
        idle_cycles(4);
        chk("final_ferr", ferr_cnt, 32'd1);
        chk("final_ovf", ovf_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
